// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: shared definitions for the instruction-memory loader.
//   state_e    - loader FSM state encoding
//   HDR_BYTES  - stream header length (4 address bytes + 2 count bytes)
//   WORD_BYTES - bytes per instruction word
package instr_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_CHECK = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_e;

  localparam int unsigned HDR_BYTES  = 6;
  localparam int unsigned WORD_BYTES = 4;

  // Value of the header byte counter while the final header byte is taken.
  localparam logic [2:0] HDR_LAST = 3'(HDR_BYTES - 1);

endpackage

// File: rtl/byte_word_packer.sv
// byte_word_packer: assembles a 32-bit little-endian word from a byte stream.
//   i_clk   - clock, rising edge
//   i_rst   - synchronous active-low reset
//   i_clr   - restart assembly at byte 0
//   i_shift - accept i_byte this cycle
//   i_byte  - incoming byte
//   o_word  - assembled word (byte k ends up at [8k+7:8k] after four shifts)
//   o_full  - the byte being shifted this cycle completes the word
module byte_word_packer
  import instr_mem_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_full
);

  logic [1:0]  cnt_q;
  logic [31:0] word_q;

  // Bytes enter at the top and move down, so the first byte lands in [7:0].
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else if (i_clr) begin
      cnt_q  <= 2'd0;
    end else if (i_shift) begin
      word_q <= {i_byte, word_q[31:8]};
      cnt_q  <= cnt_q + 2'd1;
    end
  end

  assign o_word = word_q;
  assign o_full = i_shift & (cnt_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/instr_mem_writer.sv
// instr_mem_writer: loads an instruction memory from a byte stream.
// Stream: 4-byte base address (LE), 2-byte word count N (LE), 4*N data bytes.
//   i_clk, i_rst        - clock and synchronous active-low reset
//   i_start             - begin a load (honoured only in IDLE or ERR)
//   i_rx_data/valid     - stream input; o_rx_ready accepts a byte
//   o_we/o_waddr/o_wdata- word write request, held until i_wack
//   o_cpu_hold          - keeps the core in reset while a load is active
//   o_busy/o_done/o_err - status (busy = not idle, done pulse, error level)
module instr_mem_writer
  import instr_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned AW        = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  output logic          o_rx_ready,
  output logic          o_we,
  output logic [AW-1:0] o_waddr,
  output logic [31:0]   o_wdata,
  input  logic          i_wack,
  output logic          o_cpu_hold,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  // Range check is done three bits wider than the address so base+4*N never wraps.
  localparam int unsigned    EW        = AW + 3;
  localparam logic [EW-1:0] MEM_LIMIT = EW'(MEM_BYTES);

  state_e         state_q, state_d;
  logic [2:0]     hdr_cnt_q;
  logic [47:0]    hdr_q;
  logic [15:0]    words_q;
  logic [AW-1:0]  waddr_q;
  logic           rx_ready_q, we_q, cpu_hold_q, busy_q, done_q, err_q;

  logic           accept_s, start_s, pk_shift_s, pk_full_s;
  logic [31:0]    pk_word_s;
  logic [31:0]    hdr_base_s;
  logic [15:0]    hdr_count_s;
  logic [EW-1:0]  hdr_end_s;
  logic           hdr_bad_s;

  assign accept_s    = i_rx_valid & rx_ready_q;
  assign start_s     = i_start & ((state_q == S_IDLE) | (state_q == S_ERR));
  assign pk_shift_s  = accept_s & (state_q == S_DATA);
  assign hdr_base_s  = hdr_q[31:0];
  assign hdr_count_s = hdr_q[47:32];
  assign hdr_end_s   = EW'(hdr_base_s) + (EW'(hdr_count_s) << 2);
  assign hdr_bad_s   = (hdr_base_s[1:0] != 2'b00) | (hdr_end_s > MEM_LIMIT);

  byte_word_packer u_packer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (start_s),
    .i_shift (pk_shift_s),
    .i_byte  (i_rx_data),
    .o_word  (pk_word_s),
    .o_full  (pk_full_s)
  );

  // Next-state selection for the load sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (i_start) state_d = S_HDR;
        else         state_d = state_q;
      end
      S_HDR: begin
        if (accept_s && (hdr_cnt_q == HDR_LAST)) state_d = S_CHECK;
        else                                      state_d = S_HDR;
      end
      S_CHECK: begin
        if (hdr_bad_s)                  state_d = S_ERR;
        else if (hdr_count_s == 16'd0)  state_d = S_DONE;
        else                            state_d = S_DATA;
      end
      S_DATA: begin
        if (pk_full_s) state_d = S_WRITE;
        else           state_d = S_DATA;
      end
      S_WRITE: begin
        if (i_wack) state_d = (words_q == 16'd1) ? S_DONE : S_DATA;
        else        state_d = S_WRITE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, header/address/count registers, and outputs decoded from the next state.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      hdr_cnt_q  <= 3'd0;
      hdr_q      <= 48'd0;
      words_q    <= 16'd0;
      waddr_q    <= {AW{1'b0}};
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      cpu_hold_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= (state_d == S_HDR) | (state_d == S_DATA);
      we_q       <= (state_d == S_WRITE);
      cpu_hold_q <= (state_d != S_IDLE) & (state_d != S_DONE);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
      err_q      <= (state_d == S_ERR);

      // Header bytes shift down so byte 0 ends up in hdr_q[7:0].
      if (start_s) begin
        hdr_cnt_q <= 3'd0;
      end else if (accept_s && (state_q == S_HDR)) begin
        hdr_q     <= {i_rx_data, hdr_q[47:8]};
        hdr_cnt_q <= hdr_cnt_q + 3'd1;
      end

      if (state_q == S_CHECK) begin
        waddr_q <= AW'(hdr_base_s);
        words_q <= hdr_count_s;
      end else if ((state_q == S_WRITE) && i_wack) begin
        waddr_q <= waddr_q + AW'(WORD_BYTES);
        words_q <= words_q - 16'd1;
      end
    end
  end

  assign o_rx_ready = rx_ready_q;
  assign o_we       = we_q;
  assign o_waddr    = waddr_q;
  assign o_wdata    = pk_word_s;
  assign o_cpu_hold = cpu_hold_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_instr_mem_writer.sv
// tb_instr_mem_writer: directed streams against a stream-level model of the loader.
module tb_instr_mem_writer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_rx_data = 8'd0;
  logic        i_rx_valid = 1'b0;
  logic        o_rx_ready;
  logic        o_we;
  logic [31:0] o_waddr;
  logic [31:0] o_wdata;
  logic        i_wack = 1'b0;
  logic        o_cpu_hold, o_busy, o_done, o_err;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0]  stream[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] obs_addr[8];
  logic [31:0] obs_data[8];
  int          obs_n = 0;
  int          done_seen = 0;
  int          wack_delay = 0;
  bit          wack_tied = 1'b0;
  int          we_cycles = 0;
  bit          prev_done = 1'b0;

  instr_mem_writer #(.MEM_BYTES(256), .AW(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
    .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata), .i_wack(i_wack),
    .o_cpu_hold(o_cpu_hold), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory responder plus per-cycle scoreboard, all on the falling edge.
  always @(negedge i_clk) begin
    if (wack_tied)  i_wack = 1'b1;
    else if (o_we)  i_wack = (we_cycles >= wack_delay);
    else            i_wack = 1'b0;
    if (o_we) we_cycles++;
    if (i_rst) begin
      check("hold_vs_busy", o_cpu_hold, o_busy & ~o_done);
      if (o_we) check("ready_during_write", o_rx_ready, 1'b0);
      if (o_done && prev_done) check("done_pulse_width", 2, 1);
      if (o_done) done_seen++;
      if (o_we && i_wack) begin
        check("we_length", we_cycles, wack_tied ? 1 : wack_delay + 1);
        check("write_expected", exp_addr.size() != 0, 1'b1);
        if (exp_addr.size() != 0) begin
          check("waddr", o_waddr, exp_addr.pop_front());
          check("wdata", o_wdata, exp_data.pop_front());
        end
        if (obs_n < 8) begin
          obs_addr[obs_n] = o_waddr;
          obs_data[obs_n] = o_wdata;
        end
        obs_n++;
        we_cycles = 0;
      end
    end
    if (!o_we) we_cycles = 0;
    prev_done = o_done;
  end

  task automatic make_stream(input logic [31:0] base, input logic [15:0] n,
                             input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] w;
    stream.delete();
    for (int i = 0; i < 4; i++) stream.push_back(base[8*i +: 8]);
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    for (int k = 0; k < 2 && k < int'(n); k++) begin
      w = (k == 0) ? w0 : w1;
      for (int i = 0; i < 4; i++) stream.push_back(w[8*i +: 8]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    i_rx_valid = 1'b0;
    repeat (gap) @(negedge i_clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    n = 0;
    while (!o_rx_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    check("rx_ready_timeout", n < 200, 1'b1);
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  // Stream-level model: decode the header, decide error, list the expected writes.
  task automatic model(output bit err, output int n);
    logic [31:0] base;
    base = {stream[3], stream[2], stream[1], stream[0]};
    n    = int'({stream[5], stream[4]});
    err  = (base[1:0] != 2'b00) || (longint'(base) + 4 * longint'(n) > 256);
    exp_addr.delete();
    exp_data.delete();
    if (!err)
      for (int i = 0; i < n; i++) begin
        exp_addr.push_back(base + 32'(4 * i));
        exp_data.push_back({stream[9+4*i], stream[8+4*i], stream[7+4*i], stream[6+4*i]});
      end
  endtask

  task automatic run_load(input string tag, input int gap_max, input int delay, input bit tied);
    bit err;
    int n, nbytes, cycles;
    model(err, n);
    wack_delay = delay;
    wack_tied  = tied;
    obs_n      = 0;
    done_seen  = 0;
    pulse_start();
    nbytes = err ? 6 : 6 + 4 * n;
    for (int i = 0; i < nbytes; i++) send_byte(stream[i], $urandom_range(0, gap_max));
    cycles = 0;
    while (!(o_done || o_err) && cycles < 200) begin
      @(negedge i_clk);
      cycles++;
    end
    check({tag, "_finish_timeout"}, cycles < 200, 1'b1);
    if (err || n == 0) check({tag, "_check_latency"}, cycles, 1);
    @(negedge i_clk);
    @(negedge i_clk);
    check({tag, "_write_count"}, obs_n, err ? 0 : n);
    check({tag, "_left_expected"}, exp_addr.size(), 0);
    check({tag, "_done_count"}, done_seen, err ? 0 : 1);
    check({tag, "_err"}, o_err, err);
    check({tag, "_cpu_hold"}, o_cpu_hold, err);
    check({tag, "_busy"}, o_busy, err);
    check({tag, "_we_idle"}, o_we, 1'b0);
  endtask

  initial begin
    bit err;
    int n;
    repeat (3) @(negedge i_clk);
    check("rst_we", o_we, 1'b0);
    check("rst_ready", o_rx_ready, 1'b0);
    check("rst_hold", o_cpu_hold, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_err", o_err, 1'b0);
    check("rst_waddr", o_waddr, 32'h0);
    i_rst = 1'b1;
    @(negedge i_clk);

    // Reference stream, memory always acknowledging.
    stream = '{8'h64, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
               8'h03, 8'h23, 8'h40, 8'h00, 8'h23, 8'h24, 8'h60, 8'h00};
    model(err, n);
    check("model_n", n, 2);
    check("model_addr0", exp_addr[0], 32'h64);
    check("model_data1", exp_data[1], 32'h00602423);
    run_load("tied", 0, 0, 1'b1);
    check("tied_addr0", obs_addr[0], 32'h64);
    check("tied_data0", obs_data[0], 32'h00402303);
    check("tied_addr1", obs_addr[1], 32'h68);
    check("tied_data1", obs_data[1], 32'h00602423);

    // Same stream, three-cycle acknowledge delay.
    run_load("slow", 0, 3, 1'b0);
    check("slow_data0", obs_data[0], 32'h00402303);

    // Misaligned base, then recovery from ERR with a gappy stream.
    make_stream(32'h66, 16'd1, 32'h11111111, 32'h0);
    run_load("misaligned", 0, 0, 1'b0);
    stream = '{8'h64, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
               8'h03, 8'h23, 8'h40, 8'h00, 8'h23, 8'h24, 8'h60, 8'h00};
    run_load("recover", 3, 1, 1'b0);
    check("recover_data1", obs_data[1], 32'h00602423);

    // Range boundary: 0xFC+8 exceeds 256, 0xF8+8 fits exactly.
    make_stream(32'hFC, 16'd2, 32'h0, 32'h0);
    run_load("over_end", 0, 0, 1'b0);
    make_stream(32'hF8, 16'd2, 32'h44332211, 32'h88776655);
    run_load("at_end", 2, 1, 1'b0);
    check("at_end_addr0", obs_addr[0], 32'hF8);
    check("at_end_addr1", obs_addr[1], 32'hFC);
    check("at_end_data1", obs_data[1], 32'h88776655);

    // Empty load.
    make_stream(32'h40, 16'd0, 32'h0, 32'h0);
    run_load("empty", 2, 0, 1'b0);

    // Reset while the second write is waiting for its acknowledge.
    stream = '{8'h64, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
               8'h03, 8'h23, 8'h40, 8'h00, 8'h23, 8'h24, 8'h60, 8'h00};
    model(err, n);
    wack_delay = 5;
    wack_tied  = 1'b0;
    obs_n      = 0;
    pulse_start();
    for (int i = 0; i < 14; i++) send_byte(stream[i], 0);
    check("abort_we_before", o_we, 1'b1);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("abort_we", o_we, 1'b0);
    check("abort_busy", o_busy, 1'b0);
    check("abort_hold", o_cpu_hold, 1'b0);
    check("abort_ready", o_rx_ready, 1'b0);
    check("abort_writes", obs_n, 1);
    i_rst = 1'b1;
    exp_addr.delete();
    exp_data.delete();
    @(negedge i_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/instr_mem_writer.md
INSTR_MEM_WRITER -- requirements
Module: instr_mem_writer

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 256: size of the instruction memory in bytes.
REQ-002 SHALL have parameter AW, default 32: width of the write address.
REQ-003 SHALL have port i_clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port i_start, input, 1: one-cycle pulse that begins a load; ignored unless in IDLE or ERR.
REQ-006 SHALL have port i_rx_data, input, 8: incoming stream byte.
REQ-007 SHALL have port i_rx_valid, input, 1: i_rx_data is valid.
REQ-008 SHALL have port o_rx_ready, output, 1: byte accepted on a cycle where valid and ready are both high.
REQ-009 SHALL have port o_we, output, 1: word write request to the instruction memory.
REQ-010 SHALL have port o_waddr, output, AW: byte address of the word, 4-aligned.
REQ-011 SHALL have port o_wdata, output, 32: word data, little-endian assembled.
REQ-012 SHALL have port i_wack, input, 1: memory has accepted the write this cycle.
REQ-013 SHALL have port o_cpu_hold, output, 1: holds the core in reset while a load is in progress.
REQ-014 SHALL have port o_busy, output, 1: FSM is not in IDLE.
REQ-015 SHALL have port o_done, output, 1: one-cycle pulse on successful completion.
REQ-016 SHALL have port o_err, output, 1: held high while the FSM is in ERR.

Function
REQ-017 SHALL follow the stream format: 4 bytes base address (LE), then 2 bytes word count N (LE), then 4*N data bytes.
REQ-018 SHALL implement FSM states IDLE, HDR, CHECK, DATA, WRITE, DONE, ERR.
REQ-019 IDLE/ERR -> HDR on i_start; o_rx_ready=0 in IDLE, CHECK, WRITE, DONE and ERR.
REQ-020 HDR SHALL accept 6 bytes, counted by a 3-bit byte counter, then go to CHECK.
REQ-021 CHECK SHALL last one cycle, with three outcomes:
- ERR if base[1:0]!=0 or base+4*N > MEM_BYTES; compute in AW+3 bits so no wrap occurs.
- DONE if N==0.
- DATA otherwise.
REQ-022 DATA SHALL shift bytes in: the k-th byte lands at o_wdata[8k+7:8k]; after the 4th byte go to WRITE.
REQ-023 WRITE SHALL hold o_we=1 with stable o_waddr/o_wdata until i_wack=1.
- On the i_wack cycle: o_we=0 next cycle, o_waddr += 4, word count decrements.
- Next state: DATA if words remain, else DONE.
REQ-024 The first write SHALL go to o_waddr = base.
REQ-025 i_wack high in the same cycle o_we rises SHALL complete the write in 1 cycle; i_wack outside WRITE SHALL be ignored.
REQ-026 DONE SHALL last one cycle with o_done=1 and then return to IDLE.
REQ-027 o_cpu_hold SHALL be 1 in HDR, CHECK, DATA, WRITE and ERR, and 0 in IDLE and DONE.
REQ-028 i_rx_valid with i_rx_ready low SHALL drop no bytes; the upstream holds the byte.
REQ-029 i_start outside IDLE/ERR SHALL have no effect; stream stalls of any length SHALL be tolerated.
REQ-030 Throughput SHALL be one byte per cycle in HDR/DATA, i.e. minimum 5 cycles per word with immediate i_wack.

Reset
REQ-031 On i_rst==0 at a clock edge: state=IDLE; counters, address and data registers cleared.
- Outputs: o_we=0, o_rx_ready=0, o_cpu_hold=0, o_busy=0, o_done=0, o_err=0.
REQ-032 Reset mid-load SHALL abort immediately; a pending o_we SHALL drop in the same edge.

Structure
REQ-033 FSM state encoding, header length (6) and word size (4) SHALL live in a shared package, instr_mem_pkg.
REQ-034 A sub-module byte_word_packer SHALL perform the 4-byte little-endian assembly (load, shift, full flag).
REQ-035 Target implementation size: 120-400 RTL lines.

Verification
REQ-036 Stream 64 00 00 00 02 00 03 23 40 00 23 24 60 00 with i_wack tied to 1 -> writes (0x64, 0x00402303) then (0x68, 0x00602423); o_done pulses; o_cpu_hold falls.
REQ-037 Same stream, i_wack delayed 3 cycles per write -> o_we held for 4 cycles, o_rx_ready=0 throughout, identical data written.
REQ-038 Base 0x66 -> ERR, o_err=1, no o_we; a new i_start then a valid stream -> normal load, o_err=0.
REQ-039 Base 0xFC, N=2 with MEM_BYTES=256 -> ERR; base 0xF8, N=2 -> writes to 0xF8 and 0xFC, done.
REQ-040 N=0 -> o_done 1 cycle after CHECK, no writes; i_rx_valid gaps inserted randomly between bytes -> same results as the gap-free streams.
REQ-041 i_rst=0 asserted during the second WRITE -> next cycle o_we=0, state IDLE, o_cpu_hold=0.
